// File: rtl/req_onehot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants, FSM state type and a one-hot-to-index helper for the
// request arbiter that feeds the 16-to-4 priority encoder.
//   N               : number of request lines
//   W               : index width, log2(N), matches the encoder output width
//   state_t         : arbiter FSM states
//   onehot_to_index : binary index of a one-hot word (0 for an all-zero word)
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N = 16;
  localparam int W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // OR-reduces the indices of all set bits. For a true one-hot input this is
  // exactly the index of the single set bit.
  function automatic logic [W-1:0] onehot_to_index(input logic [N-1:0] oh);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/req_onehot_arbiter_if.sv
// -----------------------------------------------------------------------------
// req_onehot_arbiter_if
// Bus between the request source / grant consumer and the arbiter.
//   req_in       : request lines, level source, edges are captured
//   mask         : 1 = line not grantable (pending still captured)
//   grant_ack    : consumer accepts the current grant
//   clear_ovf    : clears the sticky overflow bits
//   grant_onehot : one-hot grant while valid, zero otherwise
//   grant_valid  : grant present
//   pending      : pending request register
//   overflow     : sticky, new edge on an already pending line
// Modports: master = source/consumer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface req_onehot_arbiter_if #(
  parameter int N = 16
);

  logic [N-1:0] req_in;
  logic [N-1:0] mask;
  logic         grant_ack;
  logic         clear_ovf;
  logic [N-1:0] grant_onehot;
  logic         grant_valid;
  logic [N-1:0] pending;
  logic [N-1:0] overflow;

  modport master (
    output req_in, mask, grant_ack, clear_ovf,
    input  grant_onehot, grant_valid, pending, overflow
  );

  modport slave (
    input  req_in, mask, grant_ack, clear_ovf,
    output grant_onehot, grant_valid, pending, overflow
  );

endinterface

// File: rtl/req_onehot_arbiter_prio_pick.sv
// -----------------------------------------------------------------------------
// prio_pick
// Combinational highest-set-bit isolator.
//   cand_i : candidate vector
//   pick_o : one-hot word with only the highest set bit of cand_i (or zero)
//   any_o  : cand_i is nonzero
// -----------------------------------------------------------------------------
module prio_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0] cand_i,
  output logic [N-1:0] pick_o,
  output logic         any_o
);

  logic found;

  // NOTE: every output of a combinational block gets a default at the top so
  // no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    // Scan from the top so the highest index wins, matching the encoder.
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_i[i] && !found) begin
        pick_o[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_o = |cand_i;

endmodule

// File: rtl/req_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// req_onehot_arbiter
// Captures rising edges of the request lines into a pending register and
// presents the highest-index unmasked pending request as a registered one-hot
// grant, held until acknowledged. Back-to-back grants need no idle cycle.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of req_onehot_arbiter_if (requests, mask, handshake,
//           pending and overflow status)
// -----------------------------------------------------------------------------
module req_onehot_arbiter
  import arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  req_onehot_arbiter_if.slave    bus
);

  state_t       state_q, state_d;
  logic [N-1:0] req_prev_q;
  logic [N-1:0] pending_q,  pending_d;
  logic [N-1:0] overflow_q, overflow_d;
  logic [N-1:0] grant_q,    grant_d;

  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [N-1:0] pick;
  logic         pick_any;
  logic         ack_fire;

  // ---------------------------------------------------------------------------
  // Edge detect, clear and candidate vectors
  // ---------------------------------------------------------------------------
  assign rise     = bus.req_in & ~req_prev_q;
  assign ack_fire = (state_q == GRANT) && bus.grant_ack;
  assign clr      = ack_fire ? grant_q : '0;
  // Only registered pending is eligible; the acked bit is removed so the next
  // pick can load in the same cycle as the ack.
  assign cand     = pending_q & ~bus.mask & ~clr;

  prio_pick #(.N(N)) u_pick (
    .cand_i (cand),
    .pick_o (pick),
    .any_o  (pick_any)
  );

  // A rise that coincides with a clear keeps the bit set and is not an
  // overflow; clear_ovf beats a same-cycle overflow set.
  assign pending_d  = (pending_q & ~clr) | rise;
  assign overflow_d = bus.clear_ovf ? '0
                                    : (overflow_q | (rise & pending_q & ~clr));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= '0;
      grant_q    <= '0;
      // Tracking the lines during reset means a line held high through reset
      // does not look like a fresh edge afterwards; with lines low during
      // reset this register comes out as zero.
      req_prev_q <= bus.req_in;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      grant_q    <= grant_d;
      req_prev_q <= bus.req_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick;
        end
      end
      GRANT: begin
        // Grant is held even if its line gets masked; only an ack moves it.
        if (bus.grant_ack) begin
          if (pick_any) begin
            grant_d = pick;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, all straight from registers
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.grant_valid  = (state_q == GRANT);
    bus.grant_onehot = grant_q;
    bus.pending      = pending_q;
    bus.overflow     = overflow_q;
  end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
module tb_req_onehot_arbiter;
  import arb_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [3*N:0] exp_w;

  req_onehot_arbiter_if #(.N(N)) bus ();

  req_onehot_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed state word: {grant_valid, grant_onehot, pending, overflow}
  function automatic logic [3*N:0] obs();
    return {bus.grant_valid, bus.grant_onehot, bus.pending, bus.overflow};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_in    = '0;
    bus.mask      = '0;
    bus.grant_ack = 1'b0;
    bus.clear_ovf = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_w = {1'b0, 16'h0, 16'h0, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL reset_state: got %h exp %h", obs(), exp_w);
    end
  endtask

  task automatic test_single();
    bus.req_in = 16'h0004;
    tick();
    exp_w = {1'b0, 16'h0, 16'h0004, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL single_pending: got %h exp %h", obs(), exp_w);
    end
    tick();
    exp_w = {1'b1, 16'h0004, 16'h0004, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL single_grant: got %h exp %h", obs(), exp_w);
    end
    bus.req_in    = '0;
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    exp_w = {1'b0, 16'h0, 16'h0, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL single_ack: got %h exp %h", obs(), exp_w);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_g [3];
    logic [N-1:0] exp_p [3];
    exp_g = '{16'h1000, 16'h0400, 16'h0040};
    exp_p = '{16'h1440, 16'h0440, 16'h0040};
    bus.req_in = 16'h1440;
    tick();
    bus.req_in = '0;
    tick();
    bus.grant_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_w = {1'b1, exp_g[i], exp_p[i], 16'h0};
      vectors++;
      if (obs() !== exp_w) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: got %h exp %h", i, obs(), exp_w);
      end
      tick();
    end
    bus.grant_ack = 1'b0;
    exp_w = {1'b0, 16'h0, 16'h0, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL b2b_drain: got %h exp %h", obs(), exp_w);
    end
  endtask

  task automatic test_mask();
    bus.mask   = 16'hF000;
    bus.req_in = 16'h1040;
    tick();
    bus.req_in = '0;
    tick();
    exp_w = {1'b1, 16'h0040, 16'h1040, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL mask_first: got %h exp %h", obs(), exp_w);
    end
    // Masking the granted line must not withdraw the grant.
    bus.mask = 16'hFFFF;
    tick();
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL mask_hold: got %h exp %h", obs(), exp_w);
    end
    bus.mask      = '0;
    bus.grant_ack = 1'b1;
    tick();
    exp_w = {1'b1, 16'h1000, 16'h1000, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL mask_unmasked: got %h exp %h", obs(), exp_w);
    end
    tick();
    bus.grant_ack = 1'b0;
    exp_w = {1'b0, 16'h0, 16'h0, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL mask_drain: got %h exp %h", obs(), exp_w);
    end
  endtask

  task automatic test_overflow();
    bus.req_in = 16'h0004;
    tick();
    bus.req_in = '0;
    tick();
    bus.req_in = 16'h0004;
    tick();
    exp_w = {1'b1, 16'h0004, 16'h0004, 16'h0004};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL ovf_set: got %h exp %h", obs(), exp_w);
    end
    // clear_ovf beats a same-cycle set: line 0 rises while pending=0 (no set),
    // so use line 2 again after a low cycle with clear asserted.
    bus.req_in    = '0;
    bus.clear_ovf = 1'b1;
    tick();
    bus.req_in = 16'h0004;
    tick();
    bus.clear_ovf = 1'b0;
    exp_w = {1'b1, 16'h0004, 16'h0004, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL ovf_clear_priority: got %h exp %h", obs(), exp_w);
    end
    // Re-pulse on the same cycle as the ack: bit stays pending, no overflow.
    bus.req_in = '0;
    tick();
    bus.req_in    = 16'h0004;
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    bus.req_in    = '0;
    exp_w = {1'b0, 16'h0, 16'h0004, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL ovf_same_cycle: got %h exp %h", obs(), exp_w);
    end
    tick();
    exp_w = {1'b1, 16'h0004, 16'h0004, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL ovf_regrant: got %h exp %h", obs(), exp_w);
    end
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    bus.req_in = 16'h0400;
    tick();
    tick();
    exp_w = {1'b1, 16'h0400, 16'h0400, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL rst_pre_grant: got %h exp %h", obs(), exp_w);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_w = {1'b0, 16'h0, 16'h0, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL rst_dropped: got %h exp %h", obs(), exp_w);
    end
    // Line still held high: no new event.
    tick();
    tick();
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL rst_level_held: got %h exp %h", obs(), exp_w);
    end
    bus.req_in = '0;
    tick();
    bus.req_in = 16'h0400;
    tick();
    exp_w = {1'b0, 16'h0, 16'h0400, 16'h0};
    vectors++;
    if (obs() !== exp_w) begin
      miscompares++;
      $display("FAIL rst_retoggle: got %h exp %h", obs(), exp_w);
    end
    bus.req_in = '0;
    tick();
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
  endtask

  // Priority encoder behaviour: index of highest set bit.
  function automatic logic [W-1:0] enc_model(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  task automatic test_encoder_pairing();
    logic [N-1:0] m_prev, m_pend, m_ovf, m_grant, m_pick;
    logic [N-1:0] rise, clr, cand;
    logic         m_valid, ack_fire;
    do_reset();
    m_prev = '0; m_pend = '0; m_ovf = '0; m_grant = '0; m_valid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      bus.req_in    = N'($urandom & $urandom & $urandom);
      bus.mask      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      bus.grant_ack = 1'($urandom_range(0, 1));
      bus.clear_ovf = ($urandom_range(0, 15) == 0);
      rise     = bus.req_in & ~m_prev;
      ack_fire = m_valid & bus.grant_ack;
      clr      = ack_fire ? m_grant : '0;
      cand     = m_pend & ~bus.mask & ~clr;
      m_pick   = '0;
      if (cand != '0) m_pick[enc_model(cand)] = 1'b1;
      m_ovf  = bus.clear_ovf ? '0 : (m_ovf | (rise & m_pend & ~clr));
      m_pend = (m_pend & ~clr) | rise;
      m_prev = bus.req_in;
      if (!m_valid || bus.grant_ack) begin
        m_grant = m_pick;
        m_valid = (cand != '0);
      end
      tick();
      exp_w = {m_valid, m_grant, m_pend, m_ovf};
      vectors++;
      if (obs() !== exp_w) begin
        miscompares++;
        $display("FAIL rand_state cyc %0d: got %h exp %h", c, obs(), exp_w);
      end
      if (bus.grant_valid) begin
        vectors++;
        if (onehot_to_index(bus.grant_onehot) !== enc_model(m_grant)) begin
          miscompares++;
          $display("FAIL enc_index cyc %0d: got %0d exp %0d", c,
                   onehot_to_index(bus.grant_onehot), enc_model(m_grant));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_mask();
    test_overflow();
    test_reset_mid_grant();
    test_encoder_pairing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
